regfile_param: RTL
==================

Name: regfile_param

Overview:
- Parametrised successor to the team's single-bit, two-entry synchronous register file.
- DEPTH x WIDTH storage with one write port and two independent registered read ports.
- Optional write-to-read bypass and optional hardwired-zero entry 0.
- Used as a structural test block for the bfasst flow: it exercises variable-index writes/reads, read enables, reset clearing and the bypass muxing across synthesis tools.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of entries (>=2; need not be a power of two)
AW, $clog2(DEPTH), address width (derived; do not override)
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns the old contents
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
we  input  1  write enable
waddr  input  AW  write address
wdata  input  WIDTH  write data
re0  input  1  read enable, port 0
raddr0  input  AW  read address, port 0
rdata0  output  WIDTH  registered read data, port 0
re1  input  1  read enable, port 1
raddr1  input  AW  read address, port 1
rdata1  output  WIDTH  registered read data, port 1

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst; no asynchronous paths.
- Reset:
  - While rst=1 at an edge, every entry is cleared to 0 and rdata0/rdata1 become 0.
  - rst dominates any write or read in the same cycle.
  - Reset asserted mid-stream discards the pending write; the first post-reset read sees all zeros.
- Write: at an edge with we=1, rst=0 and waddr<DEPTH, entry[waddr] <= wdata.
  - waddr>=DEPTH: write is ignored and no entry changes.
  - ZERO_REG=1 and waddr=0: write is ignored.
- Read port p (p=0,1):
  - Latency is 1 cycle: at an edge with rep=1, rdatap <= value(raddrp).
  - rep=0: rdatap holds its previous value.
  - raddrp>=DEPTH returns 0. ZERO_REG=1 and raddrp=0 returns 0.
- Same-cycle read/write of the same valid, writable address:
  - BYPASS=1: rdatap gets the new wdata (write-first).
  - BYPASS=0: rdatap gets the pre-write contents (read-first).
- Both read ports may address the same entry in the same cycle; each returns the identical value.
- Ports are fully independent; there are no read-port conflicts.
- No handshake back-pressure: every enabled operation completes in its cycle.
- Storage is not otherwise initialised; the only defined start state is via rst. The bench must reset before checking.
- Widths: addresses compare as unsigned AW-bit values. No truncation of wdata.

Test Plan:
- Reset clear (WIDTH=8, DEPTH=4): write 0xA5 to each entry, pulse rst 1 cycle, read all entries on both ports -> all 0x00; rdata0=rdata1=0x00 in the cycle after reset.
- Write/read all entries: write entry i = 0x10+i for i=0..3, then raddr0=i, raddr1=3-i with re0=re1=1 -> one cycle later rdata0=0x10+i and rdata1=0x13-i.
- Read hold: read entry 2 (0x12), then drop re0 and write 0x77 to entry 2 -> rdata0 stays 0x12 until re0 is reasserted, then reads 0x77.
- Bypass collision:
  - BYPASS=1: entry1=0x11; same cycle we=1, waddr=1, wdata=0x99, re0=1, raddr0=1 -> rdata0=0x99.
  - BYPASS=0: same stimulus -> rdata0=0x11, and the next read returns 0x99.
- Non-power-of-two and ZERO_REG (DEPTH=3, ZERO_REG=1):
  - Write 0xFF to addr 0 and addr 3 -> reads of addr 0 and addr 3 return 0x00.
  - Entries 1 and 2 are unchanged.
- Reset dominance: rst=1 with we=1, waddr=2, wdata=0x5A, re1=1 at the same edge -> rdata1=0x00, and a later read of entry 2 returns 0x00.

Source files
------------

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : DEPTH x WIDTH register file, one write port, two registered read
//            ports, optional write-to-read bypass and hardwired-zero entry 0.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module regfile_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AW       = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re0,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1
);

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;

    assign w_wr_ok = we && ({1'b0, waddr} < c_depth) &&
                     !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic             w_en;
        logic [AW-1:0]    w_addr;
        logic             w_addr_ok;
        logic [WIDTH-1:0] w_val;
        logic [WIDTH-1:0] r_data;

        assign w_en      = (p == 0) ? re0    : re1;
        assign w_addr    = (p == 0) ? raddr0 : raddr1;
        assign w_addr_ok = ({1'b0, w_addr} < c_depth) &&
                           !((ZERO_REG != 0) && (w_addr == '0));

        // Out-of-range and hardwired-zero addresses read as 0.
        always_comb begin
            w_val = '0;
            if (w_addr_ok) begin
                if ((BYPASS != 0) && w_wr_ok && (waddr == w_addr)) begin
                    w_val = wdata;
                end else begin
                    w_val = r_mem[w_addr];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
            end else if (w_en) begin
                r_data <= w_val;
            end
        end
    end

    assign rdata0 = g_rd_port[0].r_data;
    assign rdata1 = g_rd_port[1].r_data;

endmodule
`default_nettype wire
